// File: rtl/iir_ctrl_pkg.sv
// Shared definitions for the IIR filter sequencing controller.
//   COEF_W        : sample and coefficient width
//   NUM_COEF      : number of coefficient registers
//   state_e       : controller FSM states
//   IDX_*         : cfg_addr index of each coefficient
package iir_ctrl_pkg;

    localparam int unsigned COEF_W   = 11;
    localparam int unsigned NUM_COEF = 6;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StDrain  = 2'd2,
        StUpdate = 2'd3
    } state_e;

    localparam logic [2:0] IDX_B0      = 3'd0;
    localparam logic [2:0] IDX_B1      = 3'd1;
    localparam logic [2:0] IDX_B2      = 3'd2;
    localparam logic [2:0] IDX_A1_NEG  = 3'd3;
    localparam logic [2:0] IDX_A1_2_A2 = 3'd4;
    localparam logic [2:0] IDX_A1A2    = 3'd5;

endpackage

// File: rtl/iir_ctrl_fifo.sv
// Synchronous FIFO for the controller input samples.
// No bypass: a written word becomes visible at the head one cycle later.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push, wdata   : write request (ignored when full) and data
//   pop           : read request (ignored when empty)
//   rdata         : current head word
//   full, empty   : occupancy flags
module iir_ctrl_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/iir_seq_ctrl.sv
// Sequencing controller for an external IIR filter: buffers upstream samples,
// issues them to the filter with a bounded number in flight, and swaps in new
// coefficients only when the filter pipeline is empty.
// Optional feature: define IIR_CTRL_WDOG_EN to add a DRAIN watchdog that, after
// 16 cycles in DRAIN with samples still outstanding, sets err and forces the
// in-flight count to zero.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   s_din, s_valid, s_ready      : upstream sample stream
//   start, stop                  : streaming requests (stop wins on a tie)
//   cfg_we, cfg_addr, cfg_data   : coefficient shadow write port
//   b0..a1a2                     : active coefficients to the filter
//   filt_din, filt_vin           : sample issue to the filter
//   filt_dout, filt_vout         : result from the filter
//   m_dout, m_valid              : registered filter result
//   busy, err                    : not-idle flag, sticky error flag
module iir_seq_ctrl
    import iir_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned MAX_INFLIGHT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COEF_W-1:0] s_din,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [COEF_W-1:0] cfg_data,
    output logic [COEF_W-1:0] b0,
    output logic [COEF_W-1:0] b1,
    output logic [COEF_W-1:0] b2,
    output logic [COEF_W-1:0] a1_neg,
    output logic [COEF_W-1:0] a1_2_a2,
    output logic [COEF_W-1:0] a1a2,
    output logic [COEF_W-1:0] filt_din,
    output logic              filt_vin,
    input  logic [COEF_W-1:0] filt_dout,
    input  logic              filt_vout,
    output logic [COEF_W-1:0] m_dout,
    output logic              m_valid,
    output logic              busy,
    output logic              err
);

    localparam logic [2:0] MAX_IF = 3'(MAX_INFLIGHT);

    state_e state_q, state_d;
    logic   pending_q, pending_d;
    logic   run_req_q, run_req_d;
    logic   stop_req_q, stop_req_d;
    logic   err_q, err_d;
    logic [2:0] inflight_q, inflight_d;

    logic [NUM_COEF-1:0][COEF_W-1:0] shadow_q, active_q;

    logic              filt_vin_q, m_valid_q;
    logic [COEF_W-1:0] filt_din_q, m_dout_q;

    logic              fifo_full, fifo_empty;
    logic [COEF_W-1:0] fifo_head;
    logic              cfg_valid, issue, vout_ok, wdog_fire;

    assign cfg_valid = cfg_we && (cfg_addr <= IDX_A1A2);

    iir_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (COEF_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .wdata (s_din),
        .pop   (issue),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef IIR_CTRL_WDOG_EN
    logic [3:0] wdog_q, wdog_d;

    always_comb begin
        wdog_fire = (state_q == StDrain) && (inflight_q != 3'd0) && (wdog_q == 4'd15);
        wdog_d    = '0;
        if (state_q == StDrain && !wdog_fire) wdog_d = wdog_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wdog_q <= '0;
        else     wdog_q <= wdog_d;
    end
`else
    assign wdog_fire = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) state_d = StRun;
                else if (pending_q) state_d = StUpdate;
            end
            StRun: begin
                if (stop || pending_q) state_d = StDrain;
            end
            StDrain: begin
                if (inflight_q == 3'd0) begin
                    if (pending_q)       state_d = StUpdate;
                    else if (stop_req_q) state_d = StIdle;
                end
            end
            StUpdate: begin
                state_d = (run_req_q && !stop_req_q) ? StRun : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Request flags, in-flight accounting and error.
    always_comb begin
        run_req_d  = run_req_q;
        stop_req_d = stop_req_q;
        pending_d  = pending_q;
        if (state_d == StIdle) begin
            run_req_d  = 1'b0;
            stop_req_d = 1'b0;
        end else if (stop) begin
            run_req_d  = 1'b0;
            stop_req_d = 1'b1;
        end else if (start) begin
            run_req_d  = 1'b1;
        end

        // A write in the UPDATE cycle wins, forcing another pass.
        if (cfg_valid)                  pending_d = 1'b1;
        else if (state_q == StUpdate)   pending_d = 1'b0;

        // Issue only when staying in RUN so filt_vin never shows outside RUN.
        issue = (state_q == StRun) && (state_d == StRun) && !fifo_empty &&
                (inflight_q < MAX_IF);

        vout_ok    = filt_vout && (inflight_q != 3'd0);
        inflight_d = inflight_q;
        if (issue && !vout_ok)      inflight_d = inflight_q + 3'd1;
        else if (!issue && vout_ok) inflight_d = inflight_q - 3'd1;

        err_d = err_q || (filt_vout && (inflight_q == 3'd0));
        if (wdog_fire) begin
            inflight_d = 3'd0;
            err_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            pending_q  <= 1'b0;
            run_req_q  <= 1'b0;
            stop_req_q <= 1'b0;
            err_q      <= 1'b0;
            inflight_q <= '0;
            shadow_q   <= '0;
            active_q   <= '0;
            filt_vin_q <= 1'b0;
            filt_din_q <= '0;
            m_valid_q  <= 1'b0;
            m_dout_q   <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            run_req_q  <= run_req_d;
            stop_req_q <= stop_req_d;
            err_q      <= err_d;
            inflight_q <= inflight_d;
            for (int i = 0; i < NUM_COEF; i++) begin
                if (cfg_valid && cfg_addr == 3'(i)) shadow_q[i] <= cfg_data;
            end
            // Copies the shadows as they were before any same-cycle write.
            if (state_q == StUpdate) active_q <= shadow_q;
            filt_vin_q <= issue;
            if (issue) filt_din_q <= fifo_head;
            m_valid_q  <= filt_vout;
            m_dout_q   <= filt_dout;
        end
    end

    assign s_ready  = !fifo_full;
    assign b0       = active_q[IDX_B0];
    assign b1       = active_q[IDX_B1];
    assign b2       = active_q[IDX_B2];
    assign a1_neg   = active_q[IDX_A1_NEG];
    assign a1_2_a2  = active_q[IDX_A1_2_A2];
    assign a1a2     = active_q[IDX_A1A2];
    assign filt_vin = filt_vin_q;
    assign filt_din = filt_din_q;
    assign m_valid  = m_valid_q;
    assign m_dout   = m_dout_q;
    assign busy     = (state_q != StIdle);
    assign err      = err_q;

endmodule
